// File: rtl/sdram_burst_access.sv
// sdram_burst_access: one ACTIVE + READ/WRITE-with-auto-precharge burst on an initialised SDRAM
module sdram_burst_access #(
    parameter int ROW_W     = 13,
    parameter int COL_W     = 10,
    parameter int BANK_W    = 2,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 4,
    parameter int T_RCD     = 2,
    parameter int CAS_LAT   = 2,
    parameter int T_WR      = 2,
    parameter int T_RP      = 2
) (
    input  logic                  iclk,
    input  logic                  ireset,
    input  logic                  ireq,
    input  logic                  iwrite,
    input  logic [ROW_W-1:0]      irow,
    input  logic [COL_W-1:0]      icolumn,
    input  logic [BANK_W-1:0]     ibank,
    input  logic                  ienb,
    input  logic [DATA_W-1:0]     idata,
    input  logic [DATA_W/8-1:0]   ibe,
    output logic                  odata_req,
    output logic [DATA_W-1:0]     ordata,
    output logic                  ordata_valid,
    output logic                  obusy,
    output logic                  ofin,
    output wire                   DRAM_CLK,
    output wire                   DRAM_CKE,
    output wire  [ROW_W-1:0]      DRAM_ADDR,
    output wire  [BANK_W-1:0]     DRAM_BA,
    output wire                   DRAM_CS_N,
    output wire                   DRAM_RAS_N,
    output wire                   DRAM_CAS_N,
    output wire                   DRAM_WE_N,
    output wire                   DRAM_UDQM,
    output wire                   DRAM_LDQM,
    inout  wire  [DATA_W-1:0]     DRAM_DQ
);
    localparam int BE_W    = DATA_W / 8;
    localparam int LAST_WR = T_RCD + BURST_LEN - 1;
    localparam int FIN_WR  = LAST_WR + T_WR + T_RP + 1;
    localparam int LAST_RD = T_RCD + CAS_LAT + BURST_LEN;
    localparam int FIN_RD  = LAST_RD + T_RP + 1;
    localparam int CW      = $clog2((FIN_WR > FIN_RD ? FIN_WR : FIN_RD) + 2);
    localparam logic [CW-1:0] C_CMD     = CW'(T_RCD);
    localparam logic [CW-1:0] C_LAST_WR = CW'(LAST_WR);
    localparam logic [CW-1:0] C_FIN_WR  = CW'(FIN_WR);
    localparam logic [CW-1:0] C_FIRST_RD = CW'(T_RCD + CAS_LAT + 1);
    localparam logic [CW-1:0] C_LAST_RD = CW'(LAST_RD);
    localparam logic [CW-1:0] C_FIN_RD  = CW'(FIN_RD);
    localparam logic [CW-1:0] C_MASK_RD = CW'(LAST_RD - 1);
    localparam logic [CW-1:0] C_REQ0    = CW'(T_RCD - 1);
    localparam logic [CW-1:0] C_REQ1    = CW'(T_RCD + BURST_LEN - 2);
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;

    typedef enum logic [3:0] {IDLE, ACT, RCD, CMD, WBURST, CASW, RBURST, RECOV, FIN} state_t;

    state_t state, state_n, after_wr;
    logic [CW-1:0] cyc, cyc_n, nc;
    logic wr_q, wr_n;
    logic [ROW_W-1:0] row_q, row_n, addr_q, addr_n, cas_addr;
    logic [COL_W-1:0] col_q, col_n;
    logic [BANK_W-1:0] bank_q, bank_n, ba_q, ba_n;
    logic [3:0] cmd_q, cmd_n;
    logic [BE_W-1:0] dqm_q, dqm_n;
    logic [DATA_W-1:0] dq_q;
    logic oe_q, oe_n, busy_n, req_n, valid_n, rmask_n;

    always_comb begin
        nc = cyc + 1'b1;
        after_wr = nc <= C_LAST_WR ? WBURST : nc == C_FIN_WR ? FIN : RECOV;
        state_n = state;
        case (state)
            IDLE:     state_n = ireq ? ACT : IDLE;
            ACT, RCD: state_n = nc == C_CMD ? CMD : RCD;
            CMD:      state_n = wr_q ? after_wr : CASW;
            WBURST:   state_n = after_wr;
            CASW:     state_n = nc == C_FIRST_RD ? RBURST : CASW;
            RBURST:   state_n = nc <= C_LAST_RD ? RBURST : nc == C_FIN_RD ? FIN : RECOV;
            RECOV:    state_n = nc == (wr_q ? C_FIN_WR : C_FIN_RD) ? FIN : RECOV;
            FIN:      state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_comb begin
        busy_n   = state_n != IDLE;
        cyc_n    = (state == IDLE || !busy_n) ? '0 : nc;
        wr_n     = state == IDLE ? iwrite : wr_q;
        row_n    = state == IDLE ? irow : row_q;
        col_n    = state == IDLE ? icolumn : col_q;
        bank_n   = state == IDLE ? ibank : bank_q;
        cas_addr = ROW_W'(col_n) | ROW_W'(1 << 10);
        cmd_n    = state_n == ACT ? CMD_ACT : state_n == CMD ? (wr_n ? CMD_WR : CMD_RD) : CMD_NOP;
        addr_n   = state_n == ACT ? row_n : state_n == CMD ? cas_addr : '0;
        ba_n     = (state_n == ACT || state_n == CMD) ? bank_n : '0;
        oe_n     = wr_n && (state_n == CMD || state_n == WBURST);
        rmask_n  = !wr_n && (state_n == CMD || state_n == CASW || state_n == RBURST) && cyc_n <= C_MASK_RD;
        dqm_n    = oe_n ? ~ibe : rmask_n ? '0 : '1;
        req_n    = busy_n && wr_n && cyc_n >= C_REQ0 && cyc_n <= C_REQ1;
        valid_n  = state_n == RBURST;
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state        <= IDLE;
            cyc          <= '0;
            wr_q         <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
            bank_q       <= '0;
            cmd_q        <= CMD_NOP;
            addr_q       <= '0;
            ba_q         <= '0;
            dqm_q        <= '1;
            dq_q         <= '0;
            oe_q         <= 1'b0;
            odata_req    <= 1'b0;
            ordata       <= '0;
            ordata_valid <= 1'b0;
            obusy        <= 1'b0;
            ofin         <= 1'b0;
        end else begin
            state        <= state_n;
            cyc          <= cyc_n;
            wr_q         <= wr_n;
            row_q        <= row_n;
            col_q        <= col_n;
            bank_q       <= bank_n;
            cmd_q        <= cmd_n;
            addr_q       <= addr_n;
            ba_q         <= ba_n;
            dqm_q        <= dqm_n;
            dq_q         <= idata;
            oe_q         <= oe_n;
            odata_req    <= req_n;
            ordata       <= valid_n ? DRAM_DQ : ordata;
            ordata_valid <= valid_n;
            obusy        <= busy_n;
            ofin         <= state_n == FIN;
        end
    end

    assign DRAM_CLK  = ienb ? ~iclk : 1'bz;
    assign DRAM_CKE  = ienb ? 1'b1 : 1'bz;
    assign DRAM_ADDR = ienb ? addr_q : {ROW_W{1'bz}};
    assign DRAM_BA   = ienb ? ba_q : {BANK_W{1'bz}};
    assign DRAM_CS_N  = ienb ? cmd_q[3] : 1'bz;
    assign DRAM_RAS_N = ienb ? cmd_q[2] : 1'bz;
    assign DRAM_CAS_N = ienb ? cmd_q[1] : 1'bz;
    assign DRAM_WE_N  = ienb ? cmd_q[0] : 1'bz;
    assign DRAM_UDQM = ienb ? dqm_q[BE_W-1] : 1'bz;
    assign DRAM_LDQM = ienb ? dqm_q[0] : 1'bz;
    assign DRAM_DQ   = (ienb && oe_q) ? dq_q : {DATA_W{1'bz}};
endmodule

// File: tb/tb_sdram_burst_access.sv
// tb_sdram_burst_access: scoreboard bench with a small SDRAM read responder; undriven pins pull high
module tb_sdram_burst_access;
    localparam int TRCD = 2, CL = 2, BL = 4, TWR = 2, TRP = 2;

    typedef struct {int c; logic [3:0] cmd; logic [12:0] addr; logic [1:0] ba; logic [1:0] dqm;} cmd_t;
    typedef struct {int c; logic [15:0] d; logic [1:0] m;} beat_t;

    logic iclk = 1'b0, ireset, ireq, iwrite, ienb;
    logic [12:0] irow;
    logic [9:0] icolumn;
    logic [1:0] ibank, ibe;
    logic [15:0] idata, ordata, mdq;
    logic odata_req, ordata_valid, obusy, ofin, mdq_en;
    tri1 dclk, dcke, cs_n, ras_n, cas_n, we_n, udqm, ldqm;
    tri1 [12:0] daddr;
    tri1 [1:0] dba;
    tri1 [15:0] ddq;

    cmd_t cmd_q[$];
    beat_t beat_q[$], rd_q[$], wd_q[$];
    int req_q[$], fin_q[$];
    int n_checks = 0, n_fail = 0, cyc = 0, rd_at = -100, a;
    logic [15:0] mem [4];

    assign ddq = mdq_en ? mdq : 16'hzzzz;

    sdram_burst_access dut (
        .iclk(iclk), .ireset(ireset), .ireq(ireq), .iwrite(iwrite), .irow(irow),
        .icolumn(icolumn), .ibank(ibank), .ienb(ienb), .idata(idata), .ibe(ibe),
        .odata_req(odata_req), .ordata(ordata), .ordata_valid(ordata_valid),
        .obusy(obusy), .ofin(ofin), .DRAM_CLK(dclk), .DRAM_CKE(dcke), .DRAM_ADDR(daddr),
        .DRAM_BA(dba), .DRAM_CS_N(cs_n), .DRAM_RAS_N(ras_n), .DRAM_CAS_N(cas_n),
        .DRAM_WE_N(we_n), .DRAM_UDQM(udqm), .DRAM_LDQM(ldqm), .DRAM_DQ(ddq)
    );

    initial forever #5 iclk = ~iclk;
    initial forever begin
        @(posedge iclk);
        cyc = cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    initial begin : monitor
        logic [3:0] c;
        cmd_t ec;
        beat_t eb;
        int er;
        forever begin
            @(negedge iclk);
            c = {cs_n, ras_n, cas_n, we_n};
            if (ienb && c !== 4'b0111) begin
                if (cmd_q.size() == 0) check("cmd_unexp", c, 4'b0111);
                else begin
                    ec = cmd_q.pop_front();
                    check("cmd_cyc", cyc, ec.c);
                    check("cmd", c, ec.cmd);
                    check("cmd_addr", daddr, ec.addr);
                    check("cmd_ba", dba, ec.ba);
                    check("cmd_dqm", {udqm, ldqm}, ec.dqm);
                end
                if (c === 4'b0101) rd_at = cyc + CL;
            end
            if (ienb && !mdq_en && ddq !== 16'hFFFF) begin
                if (beat_q.size() == 0) check("beat_unexp", ddq, 16'hFFFF);
                else begin
                    eb = beat_q.pop_front();
                    check("beat_cyc", cyc, eb.c);
                    check("beat_data", ddq, eb.d);
                    check("beat_dqm", {udqm, ldqm}, eb.m);
                end
            end
            if (!ienb)
                check("hiz", {dcke, daddr, dba, c, udqm, ldqm, ddq}, {38{1'b1}});
            if (odata_req) begin
                if (req_q.size() == 0 || wd_q.size() == 0) check("req_unexp", odata_req, 1'b0);
                else begin
                    er = req_q.pop_front();
                    check("req_cyc", cyc, er);
                    eb = wd_q.pop_front();
                    idata = eb.d;
                    ibe = eb.m;
                end
            end
            if (ordata_valid) begin
                if (rd_q.size() == 0) check("rd_unexp", ordata_valid, 1'b0);
                else begin
                    eb = rd_q.pop_front();
                    check("rd_cyc", cyc, eb.c);
                    check("rd_data", ordata, eb.d);
                end
            end
            if (ofin) begin
                if (fin_q.size() == 0) check("fin_unexp", ofin, 1'b0);
                else begin
                    er = fin_q.pop_front();
                    check("fin_cyc", cyc, er);
                end
            end
            mdq_en = cyc >= rd_at && cyc < rd_at + BL;
            mdq = mdq_en ? mem[cyc - rd_at] : 16'h0000;
        end
    end

    task automatic start(input logic wr, input logic [12:0] row, input logic [9:0] col,
                         input logic [1:0] bank, input logic [15:0] d [4],
                         input logic [1:0] be [4], input bit pins, output int act);
        @(negedge iclk);
        act = cyc + 1;
        iwrite = wr;
        irow = row;
        icolumn = col;
        ibank = bank;
        ireq = 1'b1;
        if (pins) cmd_q.push_back(cmd_t'{act, 4'b0011, row, bank, 2'b11});
        if (wr) begin
            if (pins) cmd_q.push_back(cmd_t'{act + TRCD, 4'b0100, 13'h0400 | {3'b000, col}, bank, ~be[0]});
            for (int k = 0; k < BL; k++) begin
                if (pins) beat_q.push_back(beat_t'{act + TRCD + k, d[k], ~be[k]});
                req_q.push_back(act + TRCD - 1 + k);
                wd_q.push_back(beat_t'{0, d[k], be[k]});
            end
            fin_q.push_back(act + TRCD + BL + TWR + TRP);
        end else begin
            cmd_q.push_back(cmd_t'{act + TRCD, 4'b0101, 13'h0400 | {3'b000, col}, bank, 2'b00});
            for (int k = 0; k < BL; k++) rd_q.push_back(beat_t'{act + TRCD + CL + 1 + k, mem[k], 2'b00});
            fin_q.push_back(act + TRCD + CL + BL + TRP + 1);
        end
        @(negedge iclk);
        ireq = 1'b0;
    endtask

    task automatic wait_fin(input int act, input int occ);
        int n = 0, gaps = 0;
        while (ofin !== 1'b1 && n < 50) begin
            if (obusy !== 1'b1) gaps++;
            @(negedge iclk);
            n++;
        end
        check("fin_timeout", n < 50, 1'b1);
        check("busy_gap", gaps, 0);
        check("occupancy", cyc - act + 1, occ);
        check("busy_at_fin", obusy, 1'b1);
        @(negedge iclk);
        check("busy_after", obusy, 1'b0);
        check("fin_pulse", ofin, 1'b0);
    endtask

    initial begin
        mem = '{16'h00B1, 16'h00B2, 16'h00B3, 16'h00B4};
        ireset = 1'b1; ireq = 1'b0; iwrite = 1'b0; ienb = 1'b1; irow = '0;
        icolumn = '0; ibank = '0; idata = '0; ibe = '0; mdq_en = 1'b0; mdq = '0;
        repeat (3) @(negedge iclk);
        check("rst_cmd", {cs_n, ras_n, cas_n, we_n}, 4'b0111);
        check("rst_dqm", {udqm, ldqm}, 2'b11);
        check("rst_addr_ba", {daddr, dba}, 15'h0);
        check("rst_dq", ddq, 16'hFFFF);
        check("rst_flags", {odata_req, ordata_valid, obusy, ofin}, 4'b0000);
        check("rst_ordata", ordata, 16'h0);
        ireset = 1'b0;
        @(posedge iclk);
        #1;
        check("clk_inv", {dclk, dcke}, 2'b01);

        start(1'b1, 13'h0123, 10'h045, 2'd2, '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4},
              '{2'b11, 2'b11, 2'b11, 2'b11}, 1'b1, a);
        wait_fin(a, 11);

        start(1'b0, 13'h0456, 10'h3FF, 2'd1, '{16'h0, 16'h0, 16'h0, 16'h0},
              '{2'b11, 2'b11, 2'b11, 2'b11}, 1'b1, a);
        wait_fin(a, 12);
        check("ordata_hold", ordata, 16'h00B4);

        start(1'b1, 13'h1ABC, 10'h001, 2'd3, '{16'h1111, 16'h2222, 16'h3333, 16'h4444},
              '{2'b11, 2'b01, 2'b11, 2'b11}, 1'b1, a);
        wait_fin(a, 11);

        start(1'b1, 13'h0777, 10'h200, 2'd0, '{16'h5A5A, 16'hA5A5, 16'h0F0F, 16'hF0F0},
              '{2'b11, 2'b11, 2'b10, 2'b11}, 1'b1, a);
        repeat (3) @(negedge iclk);
        irow = 13'h1FFF;
        iwrite = 1'b0;
        ireq = 1'b1;
        @(negedge iclk);
        ireq = 1'b0;
        wait_fin(a, 11);
        repeat (3) @(negedge iclk);

        start(1'b1, 13'h0042, 10'h010, 2'd1, '{16'hC001, 16'hC002, 16'hC003, 16'hC004},
              '{2'b11, 2'b11, 2'b11, 2'b11}, 1'b1, a);
        repeat (4) @(negedge iclk);
        ireset = 1'b1;
        void'(beat_q.pop_back());
        void'(fin_q.pop_back());
        @(negedge iclk);
        check("rstmid_cmd", {cs_n, ras_n, cas_n, we_n}, 4'b0111);
        check("rstmid_dqm", {udqm, ldqm}, 2'b11);
        check("rstmid_dq", ddq, 16'hFFFF);
        check("rstmid_flags", {odata_req, obusy, ofin}, 3'b000);
        ireset = 1'b0;
        repeat (4) @(negedge iclk);

        start(1'b1, 13'h0100, 10'h0AA, 2'd2, '{16'hD001, 16'hD002, 16'hD003, 16'hD004},
              '{2'b11, 2'b11, 2'b11, 2'b11}, 1'b1, a);
        wait_fin(a, 11);

        ienb = 1'b0;
        @(posedge iclk);
        #1;
        check("hiz_clk", dclk, 1'b1);
        start(1'b1, 13'h0321, 10'h123, 2'd3, '{16'hE001, 16'hE002, 16'hE003, 16'hE004},
              '{2'b11, 2'b11, 2'b11, 2'b11}, 1'b0, a);
        wait_fin(a, 11);
        ienb = 1'b1;

        start(1'b0, 13'h0999, 10'h002, 2'd0, '{16'h0, 16'h0, 16'h0, 16'h0},
              '{2'b11, 2'b11, 2'b11, 2'b11}, 1'b1, a);
        wait_fin(a, 12);
        repeat (3) @(negedge iclk);

        check("leftover", cmd_q.size() + beat_q.size() + rd_q.size() + wd_q.size() +
              req_q.size() + fin_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sdram_burst_access.md
# sdram_burst_access

Parametrised single-access SDRAM engine executing one read or write burst (ACTIVE → READ/WRITE with auto-precharge) after the memory has been initialised. Sits between the user-side request logic and the SDRAM pins, alongside the init/refresh blocks that share the command bus through `ienb`. Adds configurable burst length, read support, byte masking and programmable tRCD/CL/tWR/tRP to the single-word writer.

## Interface
- `ROW_W`, 13: row address width; also `DRAM_ADDR` width.
- `COL_W`, 10: column address width; must be ≤ 10.
- `BANK_W`, 2: bank address width.
- `DATA_W`, 16: data width; multiple of 8.
- `BURST_LEN`, 4: beats per access; legal values 1, 2, 4, 8.
- `T_RCD`, 2: ACTIVE-to-READ/WRITE delay in cycles; must be ≥ 1.
- `CAS_LAT`, 2: CAS latency; legal values 2, 3.
- `T_WR`, 2: write recovery in cycles.
- `T_RP`, 2: precharge time in cycles.

Ports:
- `iclk` in 1: clock. One clock; everything is on its rising edge.
- `ireset` in 1: synchronous, active-high reset.
- `ireq` in 1: start an access. Sampled only in IDLE.
- `iwrite` in 1: 1 = write, 0 = read. Sampled with `ireq`.
- `irow` in ROW_W, `icolumn` in COL_W, `ibank` in BANK_W: access address. Sampled with `ireq`.
- `ienb` in 1: bus grant. When 0, all DRAM_* outputs are high-Z.
- `idata` in DATA_W: write beat data. Sampled on the edge that ends an `odata_req` cycle.
- `ibe` in DATA_W/8: write byte enables, sampled with `idata`.
- `odata_req` out 1: the current cycle's ending edge consumes `idata`/`ibe`.
- `ordata` out DATA_W: read beat data.
- `ordata_valid` out 1: `ordata` is valid this cycle.
- `obusy` out 1: an access is in progress.
- `ofin` out 1: one-cycle pulse marking access completion.
- `DRAM_CLK`, `DRAM_CKE`, `DRAM_ADDR[ROW_W]`, `DRAM_BA[BANK_W]`, `DRAM_CS_N`, `DRAM_RAS_N`, `DRAM_CAS_N`, `DRAM_WE_N`, `DRAM_UDQM`, `DRAM_LDQM`: out. `DRAM_CLK` = ~`iclk` and `DRAM_CKE` = 1 when `ienb` is high.
- `DRAM_DQ` inout DATA_W: driven only during write beats while `ienb` is high; high-Z otherwise.

## Operation
- Commands as {CS,RAS,CAS,WE}: NOP 0111, ACT 0011, READ 0101, WRITE 0100. All command, address and DQ outputs are registered.
- State sequence: IDLE → ACT → RCD (T_RCD−1 NOP cycles, skipped if T_RCD = 1) → CMD → then per direction:
  - Write: WBURST → RECOV → FIN.
  - Read: CASW → RBURST → RECOV → FIN.
- IDLE → ACT:
  - On the edge sampling `ireq`=1, latch address and direction.
  - The ACT cycle drives ACT with `DRAM_ADDR`=row and `DRAM_BA`=bank.
- CMD cycle: drives WRITE or READ with `DRAM_ADDR`={zeros, A10=1, column zero-extended} and the bank.
- Write data:
  - Beat 0 is on DQ during the CMD cycle; beats 1..BURST_LEN−1 are on the following cycles.
  - Beat k data and dqm=~`ibe` come from `idata`/`ibe` sampled at the edge that starts that beat cycle.
  - `odata_req` is high for exactly BURST_LEN consecutive cycles, each immediately preceding a beat cycle.
- Read data:
  - dqm=00 from the CMD cycle through the last expected beat; 11 otherwise.
  - The first DQ capture occurs CAS_LAT cycles after the CMD cycle.
  - `ordata_valid` is high for BURST_LEN consecutive cycles, starting CAS_LAT+1 cycles after the CMD cycle.
  - `ordata` holds its value when not valid.
- RECOV: NOP cycles before FIN.
  - Write: T_WR+T_RP cycles after the last beat.
  - Read: T_RP cycles after the last `ordata_valid`.
- FIN:
  - `ofin`=1 for one cycle, then return to IDLE.
  - A new `ireq` is accepted on the first IDLE cycle.
- `obusy`=1 from the ACT cycle through the FIN cycle inclusive.
- `ireq` while busy is ignored and not queued.
- Outside write beats and the read window: command NOP, dqm 11, `DRAM_ADDR`=0, `DRAM_BA`=0.

## Timing
- Reset values: IDLE state; command NOP; dqm 11; addr/ba 0; DQ high-Z; `odata_req`, `ordata_valid`, `obusy`, `ofin` all 0; `ordata` 0.
- Reset mid-access: IDLE on the next cycle with no precharge issued. The system controller is responsible for re-precharging.
- Request to ACT latency: 1 cycle after the sampling edge. CMD is T_RCD cycles after ACT.
- Total write occupancy, ACT to FIN inclusive: T_RCD + BURST_LEN + T_WR + T_RP + 1 cycles.
- Total read occupancy, ACT to FIN inclusive: T_RCD + CAS_LAT + BURST_LEN + T_RP + 2 cycles.
- `ienb` low only tri-states the pins. The FSM keeps running.

## Test plan
- **Write, BL=4, T_RCD=2, T_WR=2, T_RP=2, row 0x0123, col 0x045, bank 2, data A1..A4:**
  - ACT addr 0x0123, then 1 NOP.
  - WRITE addr 0x0445 ba 2, then DQ A1..A4 on consecutive cycles.
  - `odata_req` high 4 cycles; `ofin` 5 cycles after the last beat.
  - Total occupancy 11 cycles.
- **Read, BL=4, CL=2, model returns B1..B4:** READ addr bit10=1; `ordata_valid` high 4 cycles starting 3 cycles after READ with `ordata` B1..B4; DQ never driven.
- **Write with `ibe`=2'b01 on beat 1:** DQM={U,L}=10 on that beat only, 00 on the others.
- **`ireq` pulsed mid-burst:** ignored; exactly one ACT issued; `obusy` stays high until `ofin`.
- **`ireset` asserted during WBURST beat 2:** next cycle NOP, dqm 11, DQ high-Z, `obusy`=0, no `ofin`; a subsequent `ireq` runs normally.
- **`ienb`=0 during a whole write:** all DRAM_* outputs high-Z; `ofin` still pulses at the nominal cycle.
